rvb_shift_dispatch: RTL and testbench

RVB_SHIFT_DISPATCH -- requirements
Module: rvb_shift_dispatch

---
 rtl/rvb_shift_dispatch.sv | 173 +++++++++++++++++
 tb/tb_rvb_shift_dispatch.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvb_shift_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : rvb_shift_dispatch
// Purpose  : Decodes a shifter-unit instruction, picks the shift amount
//            operand, and buffers the result towards the shifter with a
//            valid/ready handshake and exactly one cycle of latency.
// Config   : RVB_SHIFT_DISPATCH_SKID_EN
//              undefined -> 1-entry register, din_ready = !full || dout_ready
//              defined   -> 2-entry skid buffer, din_ready from flops only
// Revision : 1.0 - initial release
// ============================================================================
module rvb_shift_dispatch #(
    parameter int XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            din_valid,
    output logic            din_ready,
    input  logic [31:0]     din_insn,
    input  logic [XLEN-1:0] din_rs1,
    input  logic [XLEN-1:0] din_rs2,
    input  logic [XLEN-1:0] din_rs3,
    output logic            dout_valid,
    input  logic            dout_ready,
    output logic [XLEN-1:0] dout_rs1,
    output logic [XLEN-1:0] dout_rs2,
    output logic [XLEN-1:0] dout_rs3,
    output logic            dout_insn3,
    output logic            dout_insn12,
    output logic            dout_insn14,
    output logic            dout_insn26,
    output logic            dout_insn27,
    output logic            dout_insn29,
    output logic            dout_insn30,
    output logic            dout_illegal
);

    // Payload layout, LSB first: rs1, rs2, rs3, insn3, insn12, insn14,
    // insn26, insn27, insn29, insn30, illegal.
    localparam int C_PW = 3 * XLEN + 8;

    logic [6:0]      w_opcode;
    logic            w_legal;
    logic [XLEN-1:0] w_rs2_sel;
    logic [C_PW-1:0] w_din_pl;
    logic            w_push;
    logic            w_pop;
    logic [C_PW-1:0] main_q;
    logic [C_PW-1:0] main_d;
    logic            w_unused_insn;

    // Instruction bits that play no part in shifter dispatch.
    assign w_unused_insn = ^{din_insn[31], din_insn[28], din_insn[19:15],
                             din_insn[13], din_insn[11:7]};

    // Decode the incoming op into the payload stored in the buffer.
    always_comb begin
        w_opcode = din_insn[6:0];
        w_legal  = (w_opcode == 7'b0110011) || (w_opcode == 7'b0010011);
        if (XLEN == 64) begin
            w_legal = w_legal || (w_opcode == 7'b0111011) || (w_opcode == 7'b0011011);
        end
        // Immediate forms carry the shift amount in insn[25:20].
        w_rs2_sel = din_insn[5] ? din_rs2 : {{(XLEN-6){1'b0}}, din_insn[25:20]};
        w_din_pl  = {!w_legal, din_insn[30], din_insn[29], din_insn[27], din_insn[26],
                     din_insn[14], din_insn[12], din_insn[3],
                     din_rs3, w_rs2_sel, din_rs1};
    end

    assign w_push = din_valid && din_ready;
    assign w_pop  = dout_valid && dout_ready;

`ifdef RVB_SHIFT_DISPATCH_SKID_EN
    logic [1:0]      occ_q;
    logic [1:0]      occ_d;
    logic [C_PW-1:0] skid_q;
    logic [C_PW-1:0] skid_d;

    // Readiness depends only on stored occupancy, never on dout_ready.
    assign din_ready  = !reset && (occ_q != 2'd2);
    assign dout_valid = (occ_q != 2'd0);

    // Next-state for the output register and the skid slot behind it.
    always_comb begin
        occ_d  = occ_q;
        main_d = main_q;
        skid_d = skid_q;
        case ({w_push, w_pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    main_d = w_din_pl;
                    occ_d  = 2'd1;
                end else begin
                    skid_d = w_din_pl;
                    occ_d  = 2'd2;
                end
            end
            2'b01: begin
                if (occ_q == 2'd2) begin
                    main_d = skid_q;
                    occ_d  = 2'd1;
                end else begin
                    occ_d  = 2'd0;
                end
            end
            // Push and pop together only happen with one entry held.
            2'b11: begin
                main_d = w_din_pl;
            end
            default: begin
            end
        endcase
    end

    // Buffer state with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            occ_q  <= 2'd0;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            occ_q  <= occ_d;
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end
`else
    logic vld_q;
    logic vld_d;

    // A full register can still accept when it is being drained this cycle.
    assign din_ready  = !reset && (!vld_q || dout_ready);
    assign dout_valid = vld_q;

    // Next-state for the single output register.
    always_comb begin
        vld_d  = vld_q;
        main_d = main_q;
        if (w_pop) begin
            vld_d = 1'b0;
        end
        if (w_push) begin
            vld_d  = 1'b1;
            main_d = w_din_pl;
        end
    end

    // Register state with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_q  <= 1'b0;
            main_q <= '0;
        end else begin
            vld_q  <= vld_d;
            main_q <= main_d;
        end
    end
`endif

    assign dout_rs1     = main_q[XLEN-1:0];
    assign dout_rs2     = main_q[2*XLEN-1:XLEN];
    assign dout_rs3     = main_q[3*XLEN-1:2*XLEN];
    assign dout_insn3   = main_q[3*XLEN];
    assign dout_insn12  = main_q[3*XLEN+1];
    assign dout_insn14  = main_q[3*XLEN+2];
    assign dout_insn26  = main_q[3*XLEN+3];
    assign dout_insn27  = main_q[3*XLEN+4];
    assign dout_insn29  = main_q[3*XLEN+5];
    assign dout_insn30  = main_q[3*XLEN+6];
    assign dout_illegal = main_q[3*XLEN+7];

endmodule
`default_nettype wire

// File: tb/tb_rvb_shift_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_rvb_shift_dispatch
// Purpose  : Scoreboard bench for rvb_shift_dispatch (XLEN=64 main instance,
//            XLEN=32 side instance). Follows RVB_SHIFT_DISPATCH_SKID_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rvb_shift_dispatch;

`ifdef RVB_SHIFT_DISPATCH_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    typedef struct {
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [63:0] rs3;
        logic [6:0]  bits;   // {30,29,27,26,14,12,3}
        logic        ill;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [31:0] din_insn = '0;
    logic [63:0] din_rs1 = '0, din_rs2 = '0, din_rs3 = '0;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic [63:0] dout_rs1, dout_rs2, dout_rs3;
    logic        o3, o12, o14, o26, o27, o29, o30, oill;

    logic        d32_valid = 1'b0;
    logic        d32_ready;
    logic [31:0] d32_insn = '0;
    logic [31:0] d32_rs1 = '0, d32_rs2 = '0, d32_rs3 = '0;
    logic        d32_ovalid;
    logic [31:0] d32_ors1, d32_ors2, d32_ors3;
    logic        p3, p12, p14, p26, p27, p29, p30, pill;

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_pop = -10;
    int   n_pop = 0;
    int   mode = 0;      // 0: dout_ready low, 1: high, 2: random
    bit   in_rst = 1'b1;
    exp_t q[$];

    always #5 clk = ~clk;

    rvb_shift_dispatch #(.XLEN(64)) dut (
        .clock(clk), .reset(reset),
        .din_valid(din_valid), .din_ready(din_ready), .din_insn(din_insn),
        .din_rs1(din_rs1), .din_rs2(din_rs2), .din_rs3(din_rs3),
        .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_rs1(dout_rs1), .dout_rs2(dout_rs2), .dout_rs3(dout_rs3),
        .dout_insn3(o3), .dout_insn12(o12), .dout_insn14(o14), .dout_insn26(o26),
        .dout_insn27(o27), .dout_insn29(o29), .dout_insn30(o30), .dout_illegal(oill)
    );

    rvb_shift_dispatch #(.XLEN(32)) dut32 (
        .clock(clk), .reset(reset),
        .din_valid(d32_valid), .din_ready(d32_ready), .din_insn(d32_insn),
        .din_rs1(d32_rs1), .din_rs2(d32_rs2), .din_rs3(d32_rs3),
        .dout_valid(d32_ovalid), .dout_ready(1'b1),
        .dout_rs1(d32_ors1), .dout_rs2(d32_ors2), .dout_rs3(d32_ors3),
        .dout_insn3(p3), .dout_insn12(p12), .dout_insn14(p14), .dout_insn26(p26),
        .dout_insn27(p27), .dout_insn29(p29), .dout_insn30(p30), .dout_illegal(pill)
    );

    task automatic chk(input string name, input bit ok, input logic [255:0] act,
                       input logic [255:0] exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: what the shifter should receive for this instruction.
    function automatic exp_t model(input logic [31:0] insn, input logic [63:0] r1,
                                   input logic [63:0] r2, input logic [63:0] r3,
                                   input int xlen);
        exp_t e;
        logic [6:0] op;
        op     = insn[6:0];
        e.ill  = !((op == 7'h33) || (op == 7'h13) ||
                   (xlen == 64 && (op == 7'h3B || op == 7'h1B)));
        e.rs1  = r1;
        e.rs3  = r3;
        e.rs2  = insn[5] ? r2 : {58'd0, insn[25:20]};
        e.bits = {insn[30], insn[29], insn[27], insn[26], insn[14], insn[12], insn[3]};
        e.acc  = 0;
        return e;
    endfunction

    function automatic logic [199:0] act_vec();
        return {oill, o30, o29, o27, o26, o14, o12, o3, dout_rs1, dout_rs2, dout_rs3};
    endfunction

    function automatic logic [199:0] exp_vec(input exp_t e);
        return {e.ill, e.bits, e.rs1, e.rs2, e.rs3};
    endfunction

    // dout_ready driver
    initial forever begin
        @(posedge clk); #1;
        case (mode)
            0:       dout_ready = 1'b0;
            1:       dout_ready = 1'b1;
            default: dout_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor / scoreboard: everything sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (!in_rst) begin
            bit   exp_rdy;
            int   vis;
            exp_t e;
            cyc++;
            exp_rdy = SKID ? (q.size() < 2) : (q.size() == 0 || dout_ready);
            chk("din_ready", din_ready === exp_rdy, din_ready, exp_rdy);
            if (q.size() == 0) begin
                chk("spurious_valid", dout_valid === 1'b0, dout_valid, 0);
            end else begin
                vis = (q[0].acc + 1 > last_pop + 1) ? q[0].acc + 1 : last_pop + 1;
                if (cyc < vis) begin
                    chk("early_valid", dout_valid === 1'b0, dout_valid, 0);
                end else begin
                    chk("latency_valid", dout_valid === 1'b1, dout_valid, 1);
                    if (dout_valid === 1'b1) begin
                        chk("payload", act_vec() === exp_vec(q[0]), act_vec(), exp_vec(q[0]));
                        if (dout_ready) begin
                            void'(q.pop_front());
                            last_pop = cyc;
                            n_pop++;
                        end
                    end
                end
            end
            if (din_valid && din_ready) begin
                e = model(din_insn, din_rs1, din_rs2, din_rs3, 64);
                e.acc = cyc;
                q.push_back(e);
            end
        end
    end

    task automatic set_mode(input int m);
        mode = m;
        if (m == 0) dout_ready = 1'b0;
        else if (m == 1) dout_ready = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    // Offer one op until it is accepted or the bound expires.
    task automatic send_op(input logic [31:0] insn, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] c,
                           input int bound, output bit acc, output int waited);
        din_valid = 1'b1; din_insn = insn; din_rs1 = a; din_rs2 = b; din_rs3 = c;
        acc = 1'b0; waited = 0;
        for (int k = 0; k < bound && !acc; k++) begin
            @(negedge clk);
            acc = din_ready;
            waited++;
            @(posedge clk); #1;
        end
        din_valid = 1'b0;
    endtask

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [31:0] rand_insn();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 6))
            0: r[6:0] = 7'h33;
            1: r[6:0] = 7'h13;
            2: r[6:0] = 7'h3B;
            3: r[6:0] = 7'h1B;
            4: r[6:0] = 7'h03;
            default: ;
        endcase
        return r;
    endfunction

    task automatic d32_op(input logic [31:0] insn, input logic [31:0] r2);
        exp_t e;
        logic [31:0] r1, r3;
        r1 = $urandom; r3 = $urandom;
        e = model(insn, {32'd0, r1}, {32'd0, r2}, {32'd0, r3}, 32);
        @(posedge clk); #1;
        d32_valid = 1'b1; d32_insn = insn; d32_rs1 = r1; d32_rs2 = r2; d32_rs3 = r3;
        @(negedge clk);
        chk("x32_ready", d32_ready === 1'b1, d32_ready, 1);
        @(posedge clk); #1;
        d32_valid = 1'b0;
        @(negedge clk);
        chk("x32_out", {d32_ovalid, pill, p30, p29, p27, p26, p14, p12, p3,
                        d32_ors1, d32_ors2, d32_ors3} ===
                       {1'b1, e.ill, e.bits, e.rs1[31:0], e.rs2[31:0], e.rs3[31:0]},
            {d32_ovalid, pill, p30, p29, p27, p26, p14, p12, p3, d32_ors1, d32_ors2, d32_ors3},
            {1'b1, e.ill, e.bits, e.rs1[31:0], e.rs2[31:0], e.rs3[31:0]});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit acc, acc_b, acc_c;
        int w, tot, pop0;

        // Reset state
        @(posedge clk); #1;
        chk("rst_valid", dout_valid === 1'b0, dout_valid, 0);
        chk("rst_ready", din_ready === 1'b0, din_ready, 0);
        chk("rst_data", act_vec() === 200'd0, act_vec(), 0);
        @(posedge clk); #3;
        reset = 1'b0; in_rst = 1'b0;
        @(posedge clk); #1;

        // Directed ops: SLL, SRAI, LOAD
        set_mode(1);
        send_op(32'h00209033, 64'h1, 64'h4, r64(), 5, acc, w);
        chk("sll_acc", acc, acc, 1);
        send_op(32'h4050D013, r64(), '1, r64(), 5, acc, w);
        chk("srai_acc", acc, acc, 1);
        send_op(32'h00000003, r64(), r64(), r64(), 5, acc, w);
        chk("load_acc", acc, acc, 1);
        idle(3);

        // Backpressure A, B, C
        set_mode(0);
        send_op(32'h00A01033, r64(), r64(), r64(), 5, acc, w);
        chk("bp_a_acc", acc, acc, 1);
        send_op(32'h00B05013, r64(), r64(), r64(), 3, acc_b, w);
        chk("bp_b_acc", acc_b === SKID, acc_b, SKID);
        acc_c = 1'b0;
        if (acc_b) begin
            send_op(32'h40C0503B, r64(), r64(), r64(), 3, acc_c, w);
            chk("bp_c_acc", acc_c === 1'b0, acc_c, 0);
        end
        set_mode(1);
        if (!acc_b) send_op(32'h00B05013, r64(), r64(), r64(), 5, acc_b, w);
        send_op(32'h40C0503B, r64(), r64(), r64(), 5, acc_c, w);
        chk("bp_drain_acc", acc_b && acc_c, {acc_b, acc_c}, 2'b11);
        idle(4);
        chk("bp_drained", q.size() == 0, q.size(), 0);

        // Sustained throughput: 100 ops, one per cycle
        pop0 = n_pop; tot = 0;
        for (int i = 0; i < 100; i++) begin
            send_op(rand_insn(), r64(), r64(), r64(), 5, acc, w);
            tot += w;
        end
        chk("tput_cycles", tot == 100, tot, 100);
        idle(2);
        chk("tput_pops", n_pop - pop0 == 100, n_pop - pop0, 100);

        // Randomized traffic with random backpressure and gaps
        set_mode(2);
        for (int i = 0; i < 300; i++) begin
            send_op(rand_insn(), r64(), r64(), r64(), 60, acc, w);
            if (!acc) chk("accept_timeout", 1'b0, 0, 1);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        set_mode(1);
        idle(5);
        chk("rand_drained", q.size() == 0, q.size(), 0);

        // Reset between edges while an op is held
        set_mode(0);
        send_op(32'h00309033, r64(), r64(), r64(), 5, acc, w);
        @(negedge clk);
        chk("pre_rst_valid", dout_valid === 1'b1, dout_valid, 1);
        @(posedge clk); #3;
        in_rst = 1'b1; reset = 1'b1;
        #1;
        chk("async_rst_valid", dout_valid === 1'b0, dout_valid, 0);
        chk("async_rst_ready", din_ready === 1'b0, din_ready, 0);
        chk("async_rst_data", act_vec() === 200'd0, act_vec(), 0);
        q.delete();
        @(posedge clk); @(posedge clk); #3;
        set_mode(1);
        reset = 1'b0; in_rst = 1'b0;
        idle(4);

        // XLEN=32 instance: OP-32/OP-IMM-32 illegal, shifts legal
        d32_op(32'h0000003B, $urandom);
        d32_op(32'h0000001B, $urandom);
        d32_op(32'h4050D013, 32'hFFFF_FFFF);
        d32_op(32'h00209033, 32'h4);
        d32_op(32'h00000003, $urandom);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
